fifo_1rw_sched: RTL and testbench

- Scheduler in front of a single-ported (1rw) 32-bit, 16-entry FIFO. The FIFO accepts either one enqueue or one dequeue per cycle.
- Converts an independent producer valid/ready stream and consumer valid/ready stream into the FIFO's v/enq_not_deq command interface.
- Arbitrates round-robin when both sides are eligible.
- Hides the FIFO's 1-cycle dequeue read latency behind a 2-entry output buffer, so the consumer sees a plain valid/ready stream.

---
 rtl/fifo_1rw_sched_pkg.sv | 20 ++
 rtl/fifo_1rw_sched_if.sv | 31 +++
 rtl/fifo_1rw_sched_obuf.sv | 78 +++++++
 rtl/fifo_1rw_sched.sv | 135 +++++++++++++
 tb/tb_fifo_1rw_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_1rw_sched_pkg.sv
// Shared types and default sizes for the 1rw FIFO scheduler.
package fifo_1rw_sched_pkg;

   // Which side of the FIFO received the most recent command slot.
   typedef enum logic {
      GNT_ENQ = 1'b0,
      GNT_DEQ = 1'b1
   } grant_e;

   localparam int WIDTH_DEF      = 32;
   localparam int OBUF_DEPTH_DEF = 2;
   localparam int CNT_W_DEF      = 16;
   localparam int FIFO_DEPTH     = 16;

   // Pointer width for a circular buffer; a 1-entry buffer still needs one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_1rw_sched_if.sv
// Producer, consumer and FIFO command signals of the 1rw FIFO scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface fifo_1rw_sched_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in_data_i;
   logic             in_v_i;
   logic             in_ready_o;

   logic [WIDTH-1:0] out_data_o;
   logic             out_v_o;
   logic             out_yumi_i;

   logic             fifo_v_o;
   logic             fifo_enq_not_deq_o;
   logic [WIDTH-1:0] fifo_data_o;
   logic             fifo_full_i;
   logic             fifo_empty_i;
   logic [WIDTH-1:0] fifo_data_i;

   modport slave (
      input  in_data_i, in_v_i, out_yumi_i, fifo_full_i, fifo_empty_i, fifo_data_i,
      output in_ready_o, out_data_o, out_v_o, fifo_v_o, fifo_enq_not_deq_o, fifo_data_o
   );

   modport master (
      output in_data_i, in_v_i, out_yumi_i, fifo_full_i, fifo_empty_i, fifo_data_i,
      input  in_ready_o, out_data_o, out_v_o, fifo_v_o, fifo_enq_not_deq_o, fifo_data_o
   );

endinterface

// File: rtl/fifo_1rw_sched_obuf.sv
// Small circular output buffer that absorbs FIFO read returns so the
// consumer sees a plain valid/yumi stream. Push and pop may coincide.
module fifo_1rw_sched_obuf
   import fifo_1rw_sched_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int DEPTH = OBUF_DEPTH_DEF,
   localparam int PTR_W = ptr_w(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             v_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             v_q, v_d;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state for storage, pointers and occupancy; a pop of an empty buffer is dropped.
   always_comb begin
      pop     = pop_i & v_q;
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) begin
         mem_d[tail_q] = push_data_i;
         tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
         head_d = ptr_inc(head_q);
      end
      case ({push_i, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      v_d = (count_d != '0);
   end

   // Buffer state registers; valid is a flop so the consumer never sees comb logic.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         v_q     <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         v_q     <= v_d;
      end
   end

   assign data_o  = mem_q[head_q];
   assign v_o     = v_q;
   assign count_o = count_q;

endmodule

// File: rtl/fifo_1rw_sched.sv
// Scheduler in front of a single-ported FIFO: one enqueue or one dequeue per
// cycle, round-robin between producer and consumer when both are eligible,
// with the 1-cycle read latency hidden behind a small output buffer.
// Optional macro FIFO_1RW_SCHED_PERF_EN adds saturating grant/conflict counters.
//
// state (last_grant) | meaning
// GNT_ENQ            | last command was an enqueue; a tie goes to dequeue
// GNT_DEQ            | last command was a dequeue (reset); a tie goes to enqueue
module fifo_1rw_sched
   import fifo_1rw_sched_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input logic             clk_i,
   input logic             reset_n_i,
   fifo_1rw_sched_if.slave bus
`ifdef FIFO_1RW_SCHED_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_enq_o,
   output logic [CNT_W-1:0] perf_deq_o,
   output logic [CNT_W-1:0] perf_conflict_o
`endif
);

   localparam int OCNT_W = $clog2(OBUF_DEPTH + 1);
   localparam int CRED_W = $clog2(OBUF_DEPTH + 2);

   if (OBUF_DEPTH < 2 || OBUF_DEPTH > 4) begin : g_bad_obuf_depth
      $error("fifo_1rw_sched: OBUF_DEPTH must be within 2..4");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("fifo_1rw_sched: CNT_W must be positive");
   end

   grant_e            last_grant_q, last_grant_d;
   logic              rd_pending_q, rd_pending_d;
   logic              enq_ok, deq_ok;
   logic              enq_gnt, deq_gnt;
   logic [CRED_W-1:0] credit_used;
   logic [OCNT_W-1:0] obuf_count;
   logic [WIDTH-1:0]  obuf_data;
   logic              obuf_v;

   // Eligibility and round-robin grant. Credits ignore this cycle's yumi so there
   // is no yumi-to-command path. Grants are held off while reset is asserted so the
   // command outputs show their idle values immediately.
   always_comb begin
      credit_used  = CRED_W'(obuf_count) + CRED_W'(rd_pending_q);
      enq_ok       = reset_n_i & bus.in_v_i & ~bus.fifo_full_i;
      deq_ok       = reset_n_i & ~bus.fifo_empty_i & (credit_used < CRED_W'(OBUF_DEPTH));
      enq_gnt      = enq_ok & (~deq_ok | (last_grant_q == GNT_DEQ));
      deq_gnt      = deq_ok & (~enq_ok | (last_grant_q == GNT_ENQ));
      last_grant_d = last_grant_q;
      if (enq_gnt) begin
         last_grant_d = GNT_ENQ;
      end else if (deq_gnt) begin
         last_grant_d = GNT_DEQ;
      end
      rd_pending_d = deq_gnt;
   end

   // Arbiter state and the single in-flight read marker.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant_q <= GNT_DEQ;
         rd_pending_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_pending_q <= rd_pending_d;
      end
   end

   assign bus.in_ready_o         = enq_gnt;
   assign bus.fifo_v_o           = enq_gnt | deq_gnt;
   assign bus.fifo_enq_not_deq_o = enq_gnt;
   assign bus.fifo_data_o        = bus.in_data_i;

   fifo_1rw_sched_obuf #(
      .WIDTH (WIDTH),
      .DEPTH (OBUF_DEPTH)
   ) u_obuf (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .push_i      (rd_pending_q),
      .push_data_i (bus.fifo_data_i),
      .pop_i       (bus.out_yumi_i),
      .data_o      (obuf_data),
      .v_o         (obuf_v),
      .count_o     (obuf_count)
   );

   assign bus.out_data_o = obuf_data;
   assign bus.out_v_o    = obuf_v;

   yumi_needs_valid: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) bus.out_yumi_i |-> bus.out_v_o
   );

`ifdef FIFO_1RW_SCHED_PERF_EN
   logic [CNT_W-1:0] perf_enq_q, perf_enq_d;
   logic [CNT_W-1:0] perf_deq_q, perf_deq_d;
   logic [CNT_W-1:0] perf_conflict_q, perf_conflict_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // Saturating event counters; a conflict is a cycle where both sides were eligible.
   always_comb begin
      perf_enq_d      = sat_inc(perf_enq_q, enq_gnt);
      perf_deq_d      = sat_inc(perf_deq_q, deq_gnt);
      perf_conflict_d = sat_inc(perf_conflict_q, enq_ok & deq_ok);
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         perf_enq_q      <= '0;
         perf_deq_q      <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_enq_q      <= perf_enq_d;
         perf_deq_q      <= perf_deq_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_enq_o      = perf_enq_q;
   assign perf_deq_o      = perf_deq_q;
   assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_fifo_1rw_sched.sv
// Bench for fifo_1rw_sched: a cycle table driven straight onto the FIFO pins,
// hand sequences for reset/full/stall corners, and a randomized run against a
// queue-based FIFO and a rules-level reference of the scheduler.
module tb_fifo_1rw_sched;
   import fifo_1rw_sched_pkg::*;

   localparam int W  = 32;
   localparam int OD = 2;
   localparam int FD = FIFO_DEPTH;

   logic clk_i = 1'b0;
   logic reset_n_i;
   always #5 clk_i = ~clk_i;

   fifo_1rw_sched_if #(.WIDTH(W)) bus ();

`ifdef FIFO_1RW_SCHED_PERF_EN
   logic [15:0] perf_enq, perf_deq, perf_conf;
`endif

   fifo_1rw_sched #(
      .WIDTH      (W),
      .OBUF_DEPTH (OD),
      .CNT_W      (16)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
`ifdef FIFO_1RW_SCHED_PERF_EN
      ,
      .perf_enq_o      (perf_enq),
      .perf_deq_o      (perf_deq),
      .perf_conflict_o (perf_conf)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // FIFO behind the scheduler and the rules-level reference of the scheduler.
   logic [31:0] fq[$];
   logic [31:0] ref_obuf[$];
   bit          ref_pend;
   bit          ref_last_deq;
   int          n_enq, n_deq, n_conf;

   task automatic do_reset();
      reset_n_i          = 1'b0;
      bus.in_v_i         = 1'b0;
      bus.in_data_i      = '0;
      bus.out_yumi_i     = 1'b0;
      bus.fifo_full_i    = 1'b0;
      bus.fifo_empty_i   = 1'b1;
      bus.fifo_data_i    = '0;
      fq.delete();
      ref_obuf.delete();
      ref_pend     = 1'b0;
      ref_last_deq = 1'b1;
      n_enq = 0; n_deq = 0; n_conf = 0;
      repeat (2) @(posedge clk_i);
      #2 reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // One cycle with the bench FIFO attached; caller has set in_v/in_data/yumi.
   task automatic model_cycle(output bit act_v, output bit act_enq);
      bit enq_ok, deq_ok, e_enq, e_deq;
      logic [31:0] dummy;
      bus.fifo_full_i  = (fq.size() == FD);
      bus.fifo_empty_i = (fq.size() == 0);
      @(negedge clk_i);
      enq_ok = bus.in_v_i && !bus.fifo_full_i;
      deq_ok = !bus.fifo_empty_i && ((ref_obuf.size() + int'(ref_pend)) < OD);
      if (enq_ok && deq_ok) begin
         e_enq = ref_last_deq;
         e_deq = !ref_last_deq;
         n_conf++;
      end else begin
         e_enq = enq_ok;
         e_deq = deq_ok;
      end
      check("m_in_ready", bus.in_ready_o, e_enq);
      check("m_fifo_v", bus.fifo_v_o, e_enq | e_deq);
      check("m_enq_not_deq", bus.fifo_enq_not_deq_o, e_enq);
      check("m_out_v", bus.out_v_o, ref_obuf.size() != 0);
      if (ref_obuf.size() != 0) check("m_out_data", bus.out_data_o, ref_obuf[0]);
      if (e_enq) check("m_fifo_data", bus.fifo_data_o, bus.in_data_i);
      act_v   = bus.fifo_v_o;
      act_enq = bus.fifo_enq_not_deq_o;
      @(posedge clk_i);
      #1;
      if (bus.out_yumi_i && ref_obuf.size() != 0) dummy = ref_obuf.pop_front();
      if (ref_pend) ref_obuf.push_back(bus.fifo_data_i);
      ref_pend = e_deq;
      if (e_enq) begin ref_last_deq = 1'b0; n_enq++; end
      if (e_deq) begin ref_last_deq = 1'b1; n_deq++; end
      if (act_v && act_enq && fq.size() < FD) fq.push_back(bus.in_data_i);
      if (act_v && !act_enq && fq.size() != 0) bus.fifo_data_i = fq.pop_front();
   endtask

   typedef struct {
      logic        in_v;
      logic [31:0] in_data;
      logic        full;
      logic        empty;
      logic        yumi;
      logic [31:0] fdata;
      logic        e_fv;
      logic        e_enq;
      logic        e_ov;
      logic [31:0] e_od;
   } vec_t;

   vec_t vecs[12];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      bit av, aen;
      int ndeq;

      //           in_v data         full empty yumi fdata        fv enq ov od
      vecs[0]  = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0};
      vecs[1]  = '{1, 32'h11,        0, 1, 0, 32'h0,         1, 1, 0, 32'h0};
      vecs[2]  = '{1, 32'h22,        0, 0, 0, 32'h0,         1, 0, 0, 32'h0};
      vecs[3]  = '{1, 32'h33,        0, 0, 0, 32'hA1,        1, 1, 0, 32'h0};
      vecs[4]  = '{0, 32'h0,         0, 0, 0, 32'hDEAD,      1, 0, 1, 32'hA1};
      vecs[5]  = '{0, 32'h0,         0, 0, 0, 32'hA2,        0, 0, 1, 32'hA1};
      vecs[6]  = '{1, 32'h44,        1, 0, 1, 32'hDEAD,      0, 0, 1, 32'hA1};
      vecs[7]  = '{1, 32'h55,        0, 0, 0, 32'hDEAD,      1, 1, 1, 32'hA2};
      vecs[8]  = '{0, 32'h0,         0, 0, 0, 32'hDEAD,      1, 0, 1, 32'hA2};
      vecs[9]  = '{0, 32'h0,         0, 1, 1, 32'h5A,        0, 0, 1, 32'hA2};
      vecs[10] = '{0, 32'h0,         0, 1, 1, 32'hDEAD,      0, 0, 1, 32'h5A};
      vecs[11] = '{0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 0, 32'h0};

      // Reset values with a live-looking producer and non-empty FIFO.
      reset_n_i        = 1'b0;
      bus.in_v_i       = 1'b1;
      bus.in_data_i    = 32'h99;
      bus.out_yumi_i   = 1'b0;
      bus.fifo_full_i  = 1'b0;
      bus.fifo_empty_i = 1'b0;
      bus.fifo_data_i  = '0;
      #3;
      check("rst_in_ready", bus.in_ready_o, 0);
      check("rst_fifo_v", bus.fifo_v_o, 0);
      check("rst_enq_not_deq", bus.fifo_enq_not_deq_o, 0);
      check("rst_out_v", bus.out_v_o, 0);

      // Cycle table, FIFO pins driven directly.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         bus.in_v_i       = vecs[i].in_v;
         bus.in_data_i    = vecs[i].in_data;
         bus.fifo_full_i  = vecs[i].full;
         bus.fifo_empty_i = vecs[i].empty;
         bus.out_yumi_i   = vecs[i].yumi;
         bus.fifo_data_i  = vecs[i].fdata;
         @(negedge clk_i);
         check($sformatf("vec%0d_fifo_v", i), bus.fifo_v_o, vecs[i].e_fv);
         check($sformatf("vec%0d_enq_not_deq", i), bus.fifo_enq_not_deq_o, vecs[i].e_enq);
         check($sformatf("vec%0d_in_ready", i), bus.in_ready_o, vecs[i].e_enq);
         check($sformatf("vec%0d_fifo_data", i), bus.fifo_data_o, vecs[i].in_data);
         check($sformatf("vec%0d_out_v", i), bus.out_v_o, vecs[i].e_ov);
         if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), bus.out_data_o, vecs[i].e_od);
         @(posedge clk_i);
         #1;
      end

      // Full FIFO blocks the producer; releasing full grants ENQ in the same cycle.
      do_reset();
      bus.in_v_i       = 1'b1;
      bus.in_data_i    = 32'h77;
      bus.fifo_full_i  = 1'b1;
      bus.fifo_empty_i = 1'b1;
      #2;
      check("full_in_ready", bus.in_ready_o, 0);
      check("full_fifo_v", bus.fifo_v_o, 0);
      bus.fifo_full_i = 1'b0;
      #1;
      check("unfull_in_ready", bus.in_ready_o, 1);
      check("unfull_fifo_v", bus.fifo_v_o, 1);
      check("unfull_enq", bus.fifo_enq_not_deq_o, 1);
      @(posedge clk_i);
      #1;

      // Reset while a read of 0xAB is returning.
      do_reset();
      bus.fifo_empty_i = 1'b0;
      @(negedge clk_i);
      check("rstmid_deq_issued", bus.fifo_v_o & ~bus.fifo_enq_not_deq_o, 1);
      @(posedge clk_i);
      #1;
      bus.fifo_data_i = 32'hAB;
      bus.in_v_i      = 1'b1;
      #1 reset_n_i = 1'b0;
      #1;
      check("rstmid_in_ready", bus.in_ready_o, 0);
      check("rstmid_fifo_v", bus.fifo_v_o, 0);
      check("rstmid_enq_not_deq", bus.fifo_enq_not_deq_o, 0);
      check("rstmid_out_v", bus.out_v_o, 0);
      bus.in_v_i       = 1'b0;
      bus.fifo_empty_i = 1'b1;
      @(posedge clk_i);
      #2 reset_n_i = 1'b1;
      bus.fifo_data_i = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check($sformatf("rstmid_after_out_v%0d", i), bus.out_v_o, 0);
      end
      @(posedge clk_i);
      #1;

      // Consumer stalled, FIFO holding 5 entries.
      do_reset();
      for (int k = 0; k < 5; k++) fq.push_back(32'h300 + k);
      ndeq = 0;
      for (int i = 0; i < 6; i++) begin
         model_cycle(av, aen);
         if (av && !aen) ndeq++;
      end
      check("stall_deq_count", ndeq, OD);
      bus.out_yumi_i = (ref_obuf.size() != 0);
      model_cycle(av, aen);
      check("stall_yumi_cycle_fifo_v", av, 0);
      bus.out_yumi_i = 1'b0;
      model_cycle(av, aen);
      check("stall_after_yumi_deq", av & ~aen, 1);
      model_cycle(av, aen);
      check("stall_refilled_fifo_v", av, 0);

      // Steady traffic with 4 preloaded entries: strict ENQ/DEQ alternation.
      do_reset();
      for (int k = 0; k < 4; k++) fq.push_back(32'h100 + k);
      for (int i = 0; i < 20; i++) begin
         bus.in_v_i     = 1'b1;
         bus.in_data_i  = 32'h200 + i;
         bus.out_yumi_i = (ref_obuf.size() != 0);
         model_cycle(av, aen);
         check($sformatf("steady_v%0d", i), av, 1);
         check($sformatf("steady_enq%0d", i), aen, (i % 2) == 0);
      end

      // Randomized traffic: producer-heavy phase to reach full, then drain.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bus.in_v_i     = (i < 1500) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25);
         bus.in_data_i  = $urandom;
         bus.out_yumi_i = (ref_obuf.size() != 0) &&
                          ((i < 1500) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 90));
         model_cycle(av, aen);
      end
      bus.in_v_i     = 1'b0;
      bus.out_yumi_i = 1'b0;

`ifdef FIFO_1RW_SCHED_PERF_EN
      @(negedge clk_i);
      check("perf_enq", perf_enq, n_enq);
      check("perf_deq", perf_deq, n_deq);
      check("perf_conflict", perf_conf, n_conf);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
